// File: rtl/decoder_xpt_sequencer.sv
// Fetch/phase sequencer feeding the per-opcode decoders: latches the opcode,
// counts execution phases and tracks the ED-prefix state.
module decoder_xpt_sequencer (
  input  logic       clk,
  input  logic       notReset,
  input  logic [7:0] DataIn,
  input  logic       OpcodeValid,
  input  logic       Hold,
  input  logic       PR_Reset_XPT,
  input  logic       P2_Set_CM1,
  input  logic       P2_Reset_XOTR,
  output logic       enable,
  output logic [4:0] XPT,
  output logic [4:0] notXPT,
  output logic [7:0] Source,
  output logic [7:0] notSource,
  output logic       XOTR,
  output logic       CM1,
  output logic       Overrun
);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_t;

  localparam logic [7:0] PREFIX_ED = 8'hED;
  localparam logic [4:0] XPT_MAX   = 5'd31;

  state_t     state_reg, state_next;
  logic [4:0] xpt_reg, xpt_next;
  logic [7:0] source_reg, source_next;
  logic       xotr_reg, xotr_next;
  logic       overrun_reg, overrun_next;
  logic       enable_int;

  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      state_reg   <= ST_FETCH;
      xpt_reg     <= 5'd0;
      source_reg  <= 8'h00;
      xotr_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      xpt_reg     <= xpt_next;
      source_reg  <= source_next;
      xotr_reg    <= xotr_next;
      overrun_reg <= overrun_next;
    end
  end

  assign enable_int = (state_reg == ST_EXEC) && !Hold;

  always_comb begin
    state_next   = state_reg;
    xpt_next     = xpt_reg;
    source_next  = source_reg;
    xotr_next    = xotr_reg;
    overrun_next = overrun_reg;
    case (state_reg)
      ST_FETCH: begin
        if (OpcodeValid) begin
          if ((DataIn == PREFIX_ED) && !xotr_reg) begin
            // First ED is consumed as a prefix; the real opcode follows.
            xotr_next   = 1'b1;
            source_next = PREFIX_ED;
          end else begin
            source_next  = DataIn;
            xpt_next     = 5'd0;
            overrun_next = 1'b0;
            state_next   = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (enable_int) begin
          if (P2_Set_CM1) begin
            state_next = ST_FETCH;
            xpt_next   = 5'd0;
          end else if (PR_Reset_XPT) begin
            xpt_next = 5'd0;
          end else if (xpt_reg == XPT_MAX) begin
            overrun_next = 1'b1;
          end else begin
            xpt_next = xpt_reg + 5'd1;
          end
          // Prefix clear is orthogonal to the phase-control priority chain.
          if (P2_Reset_XOTR) begin
            xotr_next = 1'b0;
          end
        end
      end
      default: state_next = ST_FETCH;
    endcase
  end

  assign enable  = enable_int;
  assign CM1     = (state_reg == ST_FETCH);
  assign XPT     = xpt_reg;
  assign Source  = source_reg;
  assign XOTR    = xotr_reg;
  assign Overrun = overrun_reg;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_not_xpt
      assign notXPT[gi] = ~xpt_reg[gi];
    end
    for (genvar gi = 0; gi < 8; gi++) begin : g_not_source
      assign notSource[gi] = ~source_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_decoder_xpt_sequencer.sv
// Self-checking bench for decoder_xpt_sequencer: directed scenarios followed by
// randomized cycles, all compared against an instruction-level reference model.
module tb_decoder_xpt_sequencer;

  logic       clk = 1'b0;
  logic       notReset;
  logic [7:0] DataIn;
  logic       OpcodeValid;
  logic       Hold;
  logic       PR_Reset_XPT;
  logic       P2_Set_CM1;
  logic       P2_Reset_XOTR;
  logic       enable;
  logic [4:0] XPT;
  logic [4:0] notXPT;
  logic [7:0] Source;
  logic [7:0] notSource;
  logic       XOTR;
  logic       CM1;
  logic       Overrun;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: instruction-level view of the sequencer
  bit       m_fetching;
  int       m_phase;
  int       m_src;
  bit       m_prefixed;
  bit       m_overrun;

  always #5 clk = ~clk;

  decoder_xpt_sequencer dut (
    .clk           (clk),
    .notReset      (notReset),
    .DataIn        (DataIn),
    .OpcodeValid   (OpcodeValid),
    .Hold          (Hold),
    .PR_Reset_XPT  (PR_Reset_XPT),
    .P2_Set_CM1    (P2_Set_CM1),
    .P2_Reset_XOTR (P2_Reset_XOTR),
    .enable        (enable),
    .XPT           (XPT),
    .notXPT        (notXPT),
    .Source        (Source),
    .notSource     (notSource),
    .XOTR          (XOTR),
    .CM1           (CM1),
    .Overrun       (Overrun)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fetching = 1'b1;
    m_phase    = 0;
    m_src      = 0;
    m_prefixed = 1'b0;
    m_overrun  = 1'b0;
  endtask

  task automatic check_all();
    check_val("CM1",       CM1,       m_fetching);
    check_val("XPT",       XPT,       m_phase);
    check_val("notXPT",    notXPT,    31 - m_phase);
    check_val("Source",    Source,    m_src);
    check_val("notSource", notSource, 255 - m_src);
    check_val("XOTR",      XOTR,      m_prefixed);
    check_val("Overrun",   Overrun,   m_overrun);
    check_val("enable",    enable,    !m_fetching && !Hold);
  endtask

  task automatic idle_inputs();
    OpcodeValid   = 1'b0;
    DataIn        = 8'h00;
    Hold          = 1'b0;
    PR_Reset_XPT  = 1'b0;
    P2_Set_CM1    = 1'b0;
    P2_Reset_XOTR = 1'b0;
  endtask

  // Called just after a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    bit nf  = m_fetching;
    int np  = m_phase;
    int ns  = m_src;
    bit npx = m_prefixed;
    bit no  = m_overrun;
    bit latched = 1'b0;
    if (m_fetching) begin
      if (OpcodeValid && DataIn == 8'hED && !m_prefixed) begin
        npx = 1'b1;
        ns  = 8'hED;
      end else if (OpcodeValid) begin
        ns = DataIn; np = 0; no = 1'b0; nf = 1'b0; latched = 1'b1;
      end
    end else if (!Hold) begin
      if (P2_Reset_XOTR) npx = 1'b0;
      if (P2_Set_CM1) begin
        nf = 1'b1; np = 0;
      end else if (PR_Reset_XPT) begin
        np = 0;
      end else begin
        if (m_phase == 31) no = 1'b1;
        np = (m_phase < 31) ? m_phase + 1 : 31;
      end
    end
    @(posedge clk);
    #1;
    m_fetching = nf; m_phase = np; m_src = ns; m_prefixed = npx; m_overrun = no;
    if (latched) $display("opcode %02h latched prefixed=%0d t=%0t", ns, npx, $time);
    check_all();
    @(negedge clk);
  endtask

  task automatic fetch(input logic [7:0] op);
    idle_inputs();
    OpcodeValid = 1'b1;
    DataIn      = op;
    step();
    idle_inputs();
  endtask

  task automatic run_to(input int k);
    for (int i = 0; i < 40 && m_phase != k; i++) step();
    check_val("run_to", XPT, k);
  endtask

  // Entered at a negedge: assert reset mid-cycle, check immediately, release at next negedge.
  task automatic do_reset();
    #2;
    notReset = 1'b0;
    #1;
    model_reset();
    $display("reset asserted t=%0t", $time);
    check_all();
    @(negedge clk);
    check_all();
    notReset = 1'b1;
  endtask

  initial begin
    idle_inputs();
    notReset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    notReset = 1'b1;
    step();

    // Plain opcode, XPT 0..3 then end of instruction
    fetch(8'h3E);
    check_val("plain_nsrc", notSource, 8'hC1);
    run_to(3);
    P2_Set_CM1 = 1'b1;
    step();
    idle_inputs();
    check_val("plain_cm1", CM1, 1'b1);

    // LD A,I/R: prefix then opcode, all three pulses at phase 4
    fetch(8'hED);
    check_val("ldai_xotr", XOTR, 1'b1);
    check_val("ldai_cm1", CM1, 1'b1);
    fetch(8'h57);
    run_to(4);
    PR_Reset_XPT = 1'b1; P2_Set_CM1 = 1'b1; P2_Reset_XOTR = 1'b1;
    step();
    idle_inputs();
    check_val("ldai_end_cm1", CM1, 1'b1);
    check_val("ldai_end_xotr", XOTR, 1'b0);
    check_val("ldai_end_xpt", XPT, 5'd0);

    // Hold freezes XPT and masks pulses
    fetch(8'h11);
    run_to(2);
    for (int i = 0; i < 3; i++) begin
      Hold = 1'b1; P2_Set_CM1 = 1'b1;
      step();
      check_val("hold_xpt", XPT, 5'd2);
    end
    idle_inputs();
    step();
    step();
    check_val("hold_after", XPT, 5'd4);
    P2_Set_CM1 = 1'b1;
    step();
    idle_inputs();

    // Saturation and Overrun clear
    fetch(8'h01);
    for (int i = 0; i < 40; i++) step();
    check_val("sat_xpt", XPT, 5'd31);
    check_val("sat_ovr", Overrun, 1'b1);
    P2_Set_CM1 = 1'b1;
    step();
    fetch(8'h00);
    check_val("ovr_clear", Overrun, 1'b0);

    // Double prefix, then abort by reset at XPT=1
    P2_Set_CM1 = 1'b1;
    step();
    fetch(8'hED);
    fetch(8'hED);
    check_val("dbl_src", Source, 8'hED);
    check_val("dbl_cm1", CM1, 1'b0);
    run_to(1);
    do_reset();
    fetch(8'h21);
    check_val("post_rst_src", Source, 8'h21);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        idle_inputs();
        do_reset();
      end else begin
        OpcodeValid   = ($urandom_range(0, 2) != 0);
        DataIn        = ($urandom_range(0, 2) == 0) ? 8'hED : 8'($urandom);
        Hold          = ($urandom_range(0, 4) == 0);
        P2_Set_CM1    = ($urandom_range(0, 7) == 0);
        PR_Reset_XPT  = ($urandom_range(0, 9) == 0);
        P2_Reset_XOTR = ($urandom_range(0, 5) == 0);
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
